// File: rtl/multu_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multu_unit : unsigned WIDTH x WIDTH sequential shift-add multiplier.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module multu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  // Accumulator bit 0 is always zero before the final shift, so it is not stored.
  logic [2*WIDTH-1:1]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_shift;
  logic                 w_last;

  // Carry-preserving add into the upper half, then shift the whole product right.
  always_comb begin
    w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                + ({1'b0, r_mcand} & {(WIDTH+1){r_mplier[0]}});
    w_acc_shift = {w_sum, r_acc[WIDTH-1:1]};
    w_last      = (r_cnt == C_LAST);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == RUN);
      r_done  <= (w_state_next == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_acc    <= w_acc_shift[2*WIDTH-1:1];
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + C_ONE;
          if (w_last) begin
            r_hi <= w_acc_shift[2*WIDTH-1:WIDTH];
            r_lo <= w_acc_shift[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_multu_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multu_unit : directed self-checking bench for multu_unit (WIDTH=32).
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_multu_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multu_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Leaves the bench at the negedge one half-cycle after the start edge (cycle 1).
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; a = 32'd9; b = 32'd9;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rst_n = 1'b1; a = 32'd6; b = 32'd7;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL release_start got=%b exp=1", busy); end
    start = 1'b0;
    repeat (32) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL release_done got=%b exp=1", done); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL release_lo got=%h exp=2a", lo); end
  endtask

  task automatic test_basic;
    int busy_cyc = 0;
    int early = 0;
    launch(32'd3, 32'd5);
    for (int k = 1; k <= 32; k++) begin
      if (busy === 1'b1) busy_cyc++;
      if (done !== 1'b0) early++;
      @(negedge clk);
    end
    checks++; if (busy_cyc != 32) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=32", busy_cyc); end
    checks++; if (early != 0) begin errors++; $display("FAIL basic_early_done got=%0d exp=0", early); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done33 got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy33 got=%b exp=0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL basic_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'hF) begin errors++; $display("FAIL basic_lo got=%h exp=f", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done34 got=%b exp=0", done); end
  endtask

  task automatic test_zero;
    int hold_bad = 0;
    int early = 0;
    launch(32'h12345678, 32'h0);
    for (int k = 1; k <= 32; k++) begin
      if (hi !== 32'h0 || lo !== 32'hF) hold_bad++;
      if (done !== 1'b0) early++;
      @(negedge clk);
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL zero_hold got=%0d bad cycles exp=0", hold_bad); end
    checks++; if (early != 0) begin errors++; $display("FAIL zero_early_done got=%0d exp=0", early); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL zero_prod got=%h_%h exp=0_0", hi, lo); end
  endtask

  task automatic test_carry;
    launch(32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (32) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL carry_done got=%b exp=1", done); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL carry_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL carry_lo got=%h exp=00000001", lo); end
  endtask

  task automatic test_idle_hold;
    int bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      if (hi !== 32'hFFFFFFFE || lo !== 32'h1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_hold got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_operand_change;
    launch(32'd4, 32'd4);
    repeat (4) @(negedge clk);
    a = 32'd9; b = 32'd9;
    repeat (28) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL opchg_done got=%b exp=1", done); end
    checks++; if (hi !== 32'h0 || lo !== 32'd16) begin errors++; $display("FAIL opchg_prod got=%h_%h exp=0_10", hi, lo); end
  endtask

  task automatic test_start_held;
    int done_cnt = 0;
    int done_k = 0;
    int busy_cyc = 0;
    logic [W-1:0] lo_at = '0;
    logic busy34 = 1'b1;
    logic busy35 = 1'b0;
    @(negedge clk);
    a = 32'd2; b = 32'd7; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; done_k = k; end
      if (k <= 33 && busy === 1'b1) busy_cyc++;
      if (k == 33) lo_at = lo;
      if (k == 34) busy34 = busy;
      if (k == 35) busy35 = busy;
    end
    start = 1'b0;
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL held_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_k != 33) begin errors++; $display("FAIL held_done_cycle got=%0d exp=33", done_k); end
    checks++; if (busy_cyc != 32) begin errors++; $display("FAIL held_busy_cycles got=%0d exp=32", busy_cyc); end
    checks++; if (lo_at !== 32'd14) begin errors++; $display("FAIL held_lo got=%h exp=e", lo_at); end
    checks++; if (busy34 !== 1'b0) begin errors++; $display("FAIL held_idle34 got=%b exp=0", busy34); end
    checks++; if (busy35 !== 1'b1) begin errors++; $display("FAIL held_restart35 got=%b exp=1", busy35); end
    repeat (27) @(negedge clk);
    checks++; if (done !== 1'b1 || lo !== 32'd14) begin errors++; $display("FAIL held_second got=done%b lo%h exp=done1 loe", done, lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL held_second_pulse got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back;
    launch(32'd10, 32'd11);
    repeat (32) @(negedge clk);
    checks++; if (done !== 1'b1 || lo !== 32'd110) begin errors++; $display("FAIL b2b_first got=done%b lo%h exp=done1 lo6e", done, lo); end
    a = 32'h10000; b = 32'h10000; start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored got=%b exp=0", busy); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b exp=1", busy); end
    repeat (32) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", done); end
    checks++; if (hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL b2b_second_prod got=%h_%h exp=1_0", hi, lo); end
  endtask

  task automatic test_mid_reset;
    int bad = 0;
    launch(32'd3, 32'd5);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_flags got=busy%b done%b exp=0 0", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midrst_prod got=%h_%h exp=0_0", hi, lo); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_no_done got=%0d bad cycles exp=0", bad); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    test_reset;
    test_basic;
    test_zero;
    test_carry;
    test_idle_hold;
    test_operand_change;
    test_start_held;
    test_back_to_back;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
